// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared types and helpers for the sequential index divider.
// Holds the FSM state enum, derived-width calculators and the power-of-2 test.
// No ports; imported by div_seq and div_seq_step.
package div_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Quotient width equals the iteration count; never below one bit.
   function automatic int calc_q_w(input int seq_len);
      return (seq_len > 1) ? $clog2(seq_len) : 1;
   endfunction

   // Dividend width: divisor width plus one bit per quotient bit.
   function automatic int calc_out_w(input int in_w, input int seq_len);
      return in_w + calc_q_w(seq_len);
   endfunction

   function automatic logic is_pow2(input logic [31:0] x);
      return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/div_seq_step.sv
// div_seq_step: one restoring-division step (shift in a bit, conditional subtract).
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ports: rem_i partial remainder, bit_i next dividend bit, div_i divisor,
//        rem_o next partial remainder, qbit_o quotient bit produced this step.
module div_seq_step
   import div_seq_pkg::*;
#(
   parameter int DATA_IN_W = 5
) (
   input  logic [DATA_IN_W:0]   rem_i,
   input  logic                 bit_i,
   input  logic [DATA_IN_W-1:0] div_i,
   output logic [DATA_IN_W:0]   rem_o,
   output logic                 qbit_o
);

   logic [DATA_IN_W:0] shifted;

   // The incoming remainder is always below the divisor, so its top bit is
   // zero and the shift never loses information.
   assign shifted = {rem_i[DATA_IN_W-1:0], bit_i};

   // rem_i[DATA_IN_W] is folded in so a set top bit can only force a subtract.
   assign qbit_o = rem_i[DATA_IN_W] | (shifted >= {1'b0, div_i});
   assign rem_o  = qbit_o ? (shifted - {1'b0, div_i}) : shifted;

endmodule

// File: rtl/div_seq.sv
// div_seq: recovers index k and remainder r from Y = X*k + r (restoring divider).
// Latency: accept at T, result at T+Q_W+1 (T+1 on overflow or power-of-2 bypass).
// Backpressure: one request in flight; in_ready low until the result is taken.
// Ports: in_valid/in_ready + dividend/divisor request side;
//        out_valid/out_ready + quotient/remainder/overflow result side.
// Optional: DIV_SEQ_POW2_BYPASS_EN resolves power-of-2 divisors in one cycle.
module div_seq
   import div_seq_pkg::*;
#(
   parameter  int DATA_IN_W  = 5,
   parameter  int SEQ_LEN    = 32,
   localparam int Q_W        = calc_q_w(SEQ_LEN),
   localparam int DATA_OUT_W = calc_out_w(DATA_IN_W, SEQ_LEN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_OUT_W-1:0] dividend,
   input  logic [DATA_IN_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [Q_W-1:0]        quotient,
   output logic [DATA_IN_W-1:0]  remainder,
   output logic                  overflow
);

   localparam int CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

   state_e               state_q;
   logic [DATA_IN_W:0]   pr_q;      // partial remainder
   logic [Q_W-1:0]       sh_q;      // dividend low bits out, quotient bits in
   logic [DATA_IN_W-1:0] x_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [Q_W-1:0]       quotient_q;
   logic [DATA_IN_W-1:0] remainder_q;
   logic                 overflow_q;

   logic [DATA_IN_W:0]   pr_d;
   logic [Q_W-1:0]       sh_d;
   logic                 qbit;
   logic [DATA_IN_W-1:0] y_hi;
   logic                 pre_ovf;

   // Quotients past the sequence end only exist for non-power-of-2 SEQ_LEN.
   function automatic logic q_big(input logic [Q_W-1:0] q);
      return {1'b0, q} >= (Q_W+1)'(SEQ_LEN);
   endfunction

   assign y_hi    = dividend[DATA_OUT_W-1:Q_W];
   // Y>>Q_W >= X means k cannot fit in Q_W bits; also catches X==0.
   assign pre_ovf = (y_hi >= divisor);

   div_seq_step #(.DATA_IN_W(DATA_IN_W)) u_step (
      .rem_i  (pr_q),
      .bit_i  (sh_q[Q_W-1]),
      .div_i  (x_q),
      .rem_o  (pr_d),
      .qbit_o (qbit)
   );

   assign sh_d = (sh_q << 1) | Q_W'(qbit);

`ifdef DIV_SEQ_POW2_BYPASS_EN
   logic [Q_W-1:0]       byp_q;
   logic [DATA_IN_W-1:0] byp_r;

   // For one-hot X the quotient is a window of Y starting at log2(X).
   always_comb begin
      byp_q = '0;
      for (int i = 0; i < DATA_IN_W; i++) begin
         if (divisor[i]) byp_q = dividend[i +: Q_W];
      end
      byp_r = dividend[DATA_IN_W-1:0] & (divisor - DATA_IN_W'(1));
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pr_q        <= '0;
         sh_q        <= '0;
         x_q         <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x_q <= divisor;
                  if (pre_ovf) begin
                     state_q     <= DONE;
                     overflow_q  <= 1'b1;
                     quotient_q  <= '0;
                     remainder_q <= '0;
                  end
`ifdef DIV_SEQ_POW2_BYPASS_EN
                  else if (is_pow2(32'(divisor))) begin
                     state_q     <= DONE;
                     overflow_q  <= q_big(byp_q);
                     quotient_q  <= q_big(byp_q) ? '0 : byp_q;
                     remainder_q <= q_big(byp_q) ? '0 : byp_r;
                  end
`endif
                  else begin
                     state_q <= BUSY;
                     pr_q    <= {1'b0, y_hi};
                     sh_q    <= dividend[Q_W-1:0];
                     cnt_q   <= CNT_W'(Q_W - 1);
                  end
               end
            end
            BUSY: begin
               pr_q  <= pr_d;
               sh_q  <= sh_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  state_q     <= DONE;
                  overflow_q  <= q_big(sh_d);
                  quotient_q  <= q_big(sh_d) ? '0 : sh_d;
                  remainder_q <= q_big(sh_d) ? '0 : pr_d[DATA_IN_W-1:0];
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign overflow  = overflow_q;

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Inverse of the multiplier-sequence generator. Given a product-domain value Y and a step X, it recovers the sequence index k and the remainder r, where Y = X*k + r and k < SEQ_LEN.
- Sequential restoring divider: one quotient bit per cycle, a single shared subtractor, valid/ready on both sides.
- Sits downstream of address/offset generation to map a linear offset back to an element index.

Parameters:
- DATA_IN_W, 5: width of divisor X.
- SEQ_LEN, 32: sequence length; a legal quotient is 0..SEQ_LEN-1.
- Q_W, $clog2(SEQ_LEN): quotient width and iteration count (derived; do not override).
- DATA_OUT_W, DATA_IN_W+Q_W: width of dividend Y (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- dividend  in  DATA_OUT_W  Y.
- divisor  in  DATA_IN_W  X.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  Q_W  k.
- remainder  out  DATA_IN_W  r.
- overflow  out  1  k not representable (X==0, or Y >= X*SEQ_LEN).

Behaviour:
- Reset (async assert, sync release): state IDLE, out_valid=0, quotient=0, remainder=0, overflow=0; in_ready=1 once rst_n is high.
- Reset mid-operation aborts the divide: no result is produced and the block returns to IDLE.
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE: on in_valid&&in_ready at cycle T, latch dividend and divisor.
  - Overflow precheck: Y>>Q_W >= X. This covers X==0.
  - If the precheck fires, go to DONE at T+1 with overflow=1, quotient=0, remainder=0.
  - Otherwise load partial remainder = Y>>Q_W (DATA_IN_W+1 bits) and the low Q_W bits as a shift register, then go to BUSY with iteration counter=Q_W-1.
- BUSY, one cycle per bit, MSB first:
  - Shift the next dividend bit into the partial remainder.
  - If partial remainder >= X, subtract X and emit quotient bit 1; else emit 0.
  - After Q_W cycles, go to DONE. out_valid first asserts at T+Q_W+1.
- DONE: quotient, remainder and overflow are held stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE next cycle.
  - If the final quotient >= SEQ_LEN (non-power-of-2 SEQ_LEN only), set overflow=1 and zero quotient and remainder.
- No request overlap: a new request is accepted only in IDLE, so back-to-back throughput is one result per Q_W+2 cycles minimum.
- in_valid, dividend and divisor are ignored outside IDLE.
- Arithmetic is unsigned. Remainder is always < X when overflow=0.

Optional Feature:
- Macro: DIV_SEQ_POW2_BYPASS_EN.
- Defined: when X is nonzero, (X&(X-1))==0 and the precheck passes, go IDLE->DONE in one cycle.
  - quotient = Y>>$clog2(X), truncated to Q_W bits.
  - remainder = Y&(X-1).
  - This mirrors the power-of-2 shortcut on the multiply side.
- Undefined: every non-overflow request takes the full Q_W-cycle BUSY path. Results are identical either way; only latency differs.

Decomposition:
- div_seq_pkg holds:
  - the state enum typedef (IDLE/BUSY/DONE);
  - a function computing the derived widths;
  - the is_pow2 helper function.
- One combinational sub-module, div_seq_step.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next partial remainder and quotient bit.
  - div_seq instantiates it once in the BUSY datapath.

Test Plan (defaults, DATA_OUT_W=10, Q_W=5):
- Y=100, X=7 -> quotient=14, remainder=2, overflow=0; out_valid exactly 6 cycles after the accept edge (bypass off).
- Y=991, X=31 -> quotient=31, remainder=30, overflow=0. Then Y=992, X=31 -> overflow=1 at T+1, quotient=0, remainder=0.
- X=0, any Y (e.g. 5) -> overflow=1 one cycle after accept. in_ready=0 until out_ready handshake.
- Hold out_ready=0 for 10 cycles after Y=100, X=7 -> outputs stable at 14/2. in_valid pulses during BUSY/DONE are ignored, with no second result.
- Assert rst_n=0 in BUSY cycle 2 of Y=500, X=17, then release -> out_valid=0, in_ready=1. The next request Y=500, X=17 -> quotient=29, remainder=7.
- With DIV_SEQ_POW2_BYPASS_EN: Y=300, X=16 -> quotient=18, remainder=12 at T+1. Without it -> the same values at T+6.
